tff_bank_sequencer: RTL and testbench

- Controller for a bank of WIDTH toggle flip-flops (clk, t, q, qb) wired as a synchronous counter.
- Accepts START/STOP/STEP/CLEAR commands over a valid/ready handshake and drives per-bit toggle enables.
- Produces mod-M counting with a terminal-count pulse. Reads bank state back through q_fb.
- Sits between the system command logic and the TFF bank, which contains no arithmetic.

---
 rtl/tff_seq_pkg.sv | 16 +
 rtl/tff_toggle_gen.sv | 65 ++++++
 rtl/tff_bank_sequencer.sv | 130 +++++++++++++
 tb/tb_tff_bank_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/tff_seq_pkg.sv
// Shared encodings for the TFF bank sequencer: command opcodes and FSM states.
package tff_seq_pkg;

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_STOP  = 2'd1;
  localparam logic [1:0] OP_STEP  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_CLR  = 2'd3
  } state_t;

endpackage

// File: rtl/tff_toggle_gen.sv
// Next-toggle computation for a bank of toggle flip-flops counting modulo mod_r.
// A modulus of 0 stands for 2^WIDTH, which falls out of the wrap-around of mod_r-1.
// Optional down-counting is compiled in with the TFF_SEQ_DOWN_EN macro.
module tff_toggle_gen #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q_fb,
  input  logic [WIDTH-1:0] mod_r,
`ifdef TFF_SEQ_DOWN_EN
  input  logic             dir,
`endif
  output logic [WIDTH-1:0] t_cnt,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] last;
  logic [WIDTH-1:0] upT;
  logic             upWrap;

  assign last = mod_r - ONE;

  // Up count: ripple-carry toggles, or toggle every set bit to land on 0 at/after last
  always_comb begin
    logic acc;
    upT    = '0;
    acc    = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      upT[i] = acc;
      acc    = acc & q_fb[i];
    end
    upWrap = (q_fb >= last);
    if (upWrap) begin
      upT = q_fb;
    end
  end

`ifdef TFF_SEQ_DOWN_EN
  logic [WIDTH-1:0] dnT;
  logic             dnWrap;

  // Down count: ripple-borrow toggles, load last from 0 or from any out-of-range value
  always_comb begin
    logic acc;
    dnT    = '0;
    acc    = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      dnT[i] = acc;
      acc    = acc & ~q_fb[i];
    end
    dnWrap = (q_fb == '0);
    if (dnWrap || (q_fb > last)) begin
      dnT = q_fb ^ last;
    end
  end

  assign t_cnt = dir ? dnT : upT;
  assign wrap  = dir ? dnWrap : upWrap;
`else
  assign t_cnt = upT;
  assign wrap  = upWrap;
`endif

endmodule

// File: rtl/tff_bank_sequencer.sv
// Sequencer driving the toggle inputs of a TFF bank as a mod-M counter.
// Commands START/STOP/STEP/CLEAR arrive over a valid/ready handshake.
// Define TFF_SEQ_DOWN_EN to add the dir input and down-counting.
module tff_bank_sequencer
  import tff_seq_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MOD_RST = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_mod,
`ifdef TFF_SEQ_DOWN_EN
  input  logic             dir,
`endif
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] t_en,
  output logic             busy,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MOD_RST_W = WIDTH'(MOD_RST);

  state_t           state_q;
  logic [WIDTH-1:0] mod_q;
  logic             ready_q;
  logic             busy_q;
  logic             tc_q;
  logic             dir_q;
  logic [WIDTH-1:0] tCnt;
  logic             wrap;
  logic             countEn;
  logic             accept;

  assign accept  = cmd_valid & ready_q;
  assign countEn = (state_q == S_RUN) || (state_q == S_STEP);

  tff_toggle_gen #(
    .WIDTH (WIDTH)
  ) u_toggle_gen (
    .q_fb  (q_fb),
    .mod_r (mod_q),
`ifdef TFF_SEQ_DOWN_EN
    .dir   (dir_q),
`endif
    .t_cnt (tCnt),
    .wrap  (wrap)
  );

  // Toggle enables follow the state: count pattern, clear-to-zero pattern, or hold
  always_comb begin
    t_en = '0;
    if (countEn) begin
      t_en = tCnt;
    end else if (state_q == S_CLR) begin
      t_en = q_fb;
    end
  end

  // Command FSM with registered ready/busy and the terminal-count pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mod_q   <= MOD_RST_W;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      tc_q    <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      tc_q <= countEn & wrap;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            case (cmd_op)
              OP_START: begin
                state_q <= S_RUN;
                mod_q   <= cmd_mod;
`ifdef TFF_SEQ_DOWN_EN
                dir_q   <= dir;
`endif
                busy_q  <= 1'b1;
              end
              OP_STEP: begin
                state_q <= S_STEP;
                mod_q   <= cmd_mod;
`ifdef TFF_SEQ_DOWN_EN
                dir_q   <= dir;
`endif
                ready_q <= 1'b0;
                busy_q  <= 1'b1;
              end
              OP_CLEAR: begin
                state_q <= S_CLR;
                ready_q <= 1'b0;
                busy_q  <= 1'b1;
              end
              default: begin
                state_q <= S_IDLE;
              end
            endcase
          end
        end
        S_RUN: begin
          if (accept) begin
            if (cmd_op == OP_STOP) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else if (cmd_op == OP_CLEAR) begin
              state_q <= S_CLR;
              ready_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign tc        = tc_q;

endmodule

// File: tb/tb_tff_bank_sequencer.sv
// Directed self-checking bench for tff_bank_sequencer with a behavioural TFF bank.
module tb_tff_bank_sequencer;
  import tff_seq_pkg::*;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             cmdValid;
  logic             cmdReady;
  logic [1:0]       cmdOp;
  logic [WIDTH-1:0] cmdMod;
  logic             dirIn;
  logic [WIDTH-1:0] bank;
  logic [WIDTH-1:0] tEn;
  logic             busyOut;
  logic             tcOut;
  logic             loadEn;
  logic [WIDTH-1:0] loadVal;

  int checks   = 0;
  int failures = 0;

  tff_bank_sequencer #(
    .WIDTH   (WIDTH),
    .MOD_RST (10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmdValid),
    .cmd_ready (cmdReady),
    .cmd_op    (cmdOp),
    .cmd_mod   (cmdMod),
`ifdef TFF_SEQ_DOWN_EN
    .dir       (dirIn),
`endif
    .q_fb      (bank),
    .t_en      (tEn),
    .busy      (busyOut),
    .tc        (tcOut)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural TFF bank, with a bench-side load used to plant arbitrary q values
  always @(posedge clk) begin
    if (loadEn) bank <= loadVal;
    else        bank <= bank ^ tEn;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [WIDTH-1:0] m);
    cmdValid = v;
    cmdOp    = op;
    cmdMod   = m;
  endtask

  task automatic sendCmd(input logic [1:0] op, input logic [WIDTH-1:0] m);
    applyStimulus(1'b1, op, m);
    tick();
    applyStimulus(1'b0, OP_STOP, '0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    dirIn   = 1'b0;
    loadEn  = 1'b1;
    loadVal = 4'd6;
    applyStimulus(1'b0, OP_STOP, '0);
    tick();
    loadEn = 1'b0;

    // Reset state
    checkOutput("rst_ready", 32'(cmdReady), 32'd1);
    checkOutput("rst_busy",  32'(busyOut),  32'd0);
    checkOutput("rst_tc",    32'(tcOut),    32'd0);
    checkOutput("rst_ten",   32'(tEn),      32'd0);

    // CLEAR from IDLE drives the bank from 6 to 0
    rst_n = 1'b1;
    sendCmd(OP_CLEAR, '0);
    checkOutput("clr_ten",   32'(tEn),      32'd6);
    checkOutput("clr_ready", 32'(cmdReady), 32'd0);
    checkOutput("clr_busy",  32'(busyOut),  32'd1);
    tick();
    checkOutput("clr_bank",  32'(bank),     32'd0);
    checkOutput("clr_tc",    32'(tcOut),    32'd0);
    checkOutput("clr_idle",  32'(busyOut),  32'd0);

    // START mod 10: 0..9,0 with tc after each 9->0
    sendCmd(OP_START, 4'd10);
    for (int c = 0; c <= 20; c++) begin
      checkOutput($sformatf("m10_bank%0d", c), 32'(bank), 32'(c % 10));
      checkOutput($sformatf("m10_tc%0d", c), 32'(tcOut), 32'((c > 0) && (c % 10 == 0)));
      tick();
    end
    checkOutput("m10_bank21", 32'(bank), 32'd1);
    sendCmd(OP_STOP, '0);
    checkOutput("stop1_bank", 32'(bank), 32'd2);
    checkOutput("stop1_busy", 32'(busyOut), 32'd0);
    tick();
    checkOutput("stop1_hold", 32'(bank), 32'd2);
    checkOutput("stop1_ten",  32'(tEn),  32'd0);

    // START mod 0 (full 2^WIDTH): 0..15,0, then STOP at 7 lands on 8
    sendCmd(OP_CLEAR, '0);
    tick();
    checkOutput("clr2_bank", 32'(bank), 32'd0);
    sendCmd(OP_START, 4'd0);
    for (int c = 0; c <= 16; c++) begin
      checkOutput($sformatf("m16_bank%0d", c), 32'(bank), 32'(c % 16));
      checkOutput($sformatf("m16_tc%0d", c), 32'(tcOut), 32'(c == 16));
      tick();
    end
    for (int c = 0; c < 6; c++) tick();
    checkOutput("m16_at7", 32'(bank), 32'd7);
    sendCmd(OP_STOP, '0);
    checkOutput("stop2_bank", 32'(bank), 32'd8);
    checkOutput("stop2_busy", 32'(busyOut), 32'd0);
    tick();
    checkOutput("stop2_hold", 32'(bank), 32'd8);

    // Out-of-range q=12 with mod 10 recovers to 0 then counts on
    sendCmd(OP_START, 4'd10);
    loadVal = 4'd12;
    loadEn  = 1'b1;
    tick();
    loadEn  = 1'b0;
    checkOutput("oor_ten",   32'(tEn),  32'd12);
    tick();
    checkOutput("oor_zero",  32'(bank), 32'd0);
    tick();
    checkOutput("oor_one",   32'(bank), 32'd1);
    sendCmd(OP_STOP, '0);

    // STEP from IDLE at q=3: one count edge, ready low for one cycle
    loadVal = 4'd3;
    loadEn  = 1'b1;
    tick();
    loadEn  = 1'b0;
    sendCmd(OP_STEP, 4'd10);
    checkOutput("step_ready", 32'(cmdReady), 32'd0);
    checkOutput("step_busy",  32'(busyOut),  32'd1);
    checkOutput("step_ten",   32'(tEn),      32'd7);
    tick();
    checkOutput("step_bank",  32'(bank),     32'd4);
    checkOutput("step_rdy2",  32'(cmdReady), 32'd1);
    checkOutput("step_idle",  32'(busyOut),  32'd0);
    checkOutput("step_tc",    32'(tcOut),    32'd0);

    // Modulus 1: bank pinned at 0, tc every count cycle
    sendCmd(OP_START, 4'd1);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput($sformatf("m1_bank%0d", c), 32'(bank),  32'd0);
      checkOutput($sformatf("m1_tc%0d", c),   32'(tcOut), 32'd1);
    end
    sendCmd(OP_STOP, '0);
    tick();
    checkOutput("m1_tcoff", 32'(tcOut), 32'd0);

    // CLEAR during RUN: accept edge still counts 5->6, then CLR zeroes with no tc
    sendCmd(OP_START, 4'd10);
    for (int c = 0; c < 5; c++) tick();
    checkOutput("crun_at5", 32'(bank), 32'd5);
    sendCmd(OP_CLEAR, '0);
    checkOutput("crun_bank6", 32'(bank),  32'd6);
    checkOutput("crun_ten",   32'(tEn),   32'd6);
    tick();
    checkOutput("crun_bank0", 32'(bank),    32'd0);
    checkOutput("crun_tc",    32'(tcOut),   32'd0);
    checkOutput("crun_idle",  32'(busyOut), 32'd0);

    // Asynchronous reset mid-RUN freezes the bank; restart continues from there
    sendCmd(OP_START, 4'd3);
    tick();
    tick();
    checkOutput("ar_pre", 32'(bank), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("ar_ten",   32'(tEn),     32'd0);
    checkOutput("ar_busy",  32'(busyOut), 32'd0);
    checkOutput("ar_ready", 32'(cmdReady), 32'd1);
    tick();
    checkOutput("ar_frozen", 32'(bank), 32'd2);
    rst_n = 1'b1;
    sendCmd(OP_START, 4'd10);
    checkOutput("ar_resume", 32'(bank), 32'd2);
    tick();
    checkOutput("ar_three", 32'(bank), 32'd3);
    for (int c = 0; c < 6; c++) tick();
    checkOutput("ar_nine", 32'(bank), 32'd9);
    tick();
    checkOutput("ar_wrap", 32'(bank),  32'd0);
    checkOutput("ar_tc",   32'(tcOut), 32'd1);
    sendCmd(OP_STOP, '0);

`ifdef TFF_SEQ_DOWN_EN
    // Down count mod 10 from 0: 9,8,..,0,9 with tc after 0->9
    sendCmd(OP_CLEAR, '0);
    tick();
    dirIn = 1'b1;
    sendCmd(OP_START, 4'd10);
    dirIn = 1'b0;
    for (int c = 0; c <= 11; c++) begin
      checkOutput($sformatf("dn_bank%0d", c), 32'(bank), 32'((10 - (c % 10)) % 10));
      checkOutput($sformatf("dn_tc%0d", c), 32'(tcOut), 32'((c == 1) || (c == 11)));
      tick();
    end
    sendCmd(OP_STOP, '0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
